// File: rtl/alu_bus_master.sv
// alu_bus_master
//    Bus initiator for the Argon ALU command protocol. It takes one request
//    (A, B, opcode, optional F preload) and drives the full command sequence
//    on the shared bus: latch operands, compute, then read back Y and F.
//    When both reads are done it returns the captured values with a
//    one-cycle done pulse. The command codes match the ALU's command set;
//    the idle command is COM_NOP.
//
//    Optional feature: define ALU_MASTER_TIMEOUT_EN to bound the read waits.
//    Each read may then wait at most TIMEOUT cycles for i_valid. If the limit
//    is reached the master finishes with o_error=1, and any output it has
//    not read keeps its previous value. Without the macro the reads wait
//    indefinitely and o_error is tied to 0.
//
// Ports
//    i_Clk, i_Reset_n      clock (rising edge), async active-low reset
//    i_start               request strobe, sampled only while idle
//    i_a, i_b, i_op        operands and ALU opcode
//    i_use_f, i_f          optional flag preload (carry-in)
//    o_busy, o_done        busy while not idle; done pulse with results
//    o_error               with o_done: a read timed out
//    o_y, o_flags          captured result and flags, held until next done
//    o_command, o_data,    bus command, write data and write-data valid
//    o_valid
//    i_data, i_valid       bus read data and read-data valid from the ALU
//
// State | meaning
//    IDLE | waiting for i_start
//    LA   | COM_LATCHA with operand A
//    LB   | COM_LATCHB with operand B
//    LF   | COM_LATCHF with flag preload (only when use_f)
//    LOP  | COM_LATCHOP with opcode
//    COMP | COM_COMPUTE; the ALU latches Y/F at the end of this cycle
//    RDY  | COM_OUTPUTY, wait for i_valid and capture Y
//    RDF  | COM_OUTPUTF, wait for i_valid and capture F
//    DONE | done pulse; results are on o_y/o_flags
module alu_bus_master #(
   parameter int WORDSIZE = 16,
   parameter int TIMEOUT  = 8
) (
   input  logic                i_Clk,
   input  logic                i_Reset_n,
   input  logic                i_start,
   input  logic [WORDSIZE-1:0] i_a,
   input  logic [WORDSIZE-1:0] i_b,
   input  logic [3:0]          i_op,
   input  logic                i_use_f,
   input  logic [WORDSIZE-1:0] i_f,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_error,
   output logic [WORDSIZE-1:0] o_y,
   output logic [WORDSIZE-1:0] o_flags,
   output logic [3:0]          o_command,
   output logic [WORDSIZE-1:0] o_data,
   output logic                o_valid,
   input  logic [WORDSIZE-1:0] i_data,
   input  logic                i_valid
);

   localparam logic [3:0] COM_NOP     = 4'd0;
   localparam logic [3:0] COM_LATCHA  = 4'd1;
   localparam logic [3:0] COM_LATCHB  = 4'd2;
   localparam logic [3:0] COM_LATCHF  = 4'd3;
   localparam logic [3:0] COM_LATCHOP = 4'd4;
   localparam logic [3:0] COM_COMPUTE = 4'd5;
   localparam logic [3:0] COM_OUTPUTY = 4'd6;
   localparam logic [3:0] COM_OUTPUTF = 4'd7;

   // The wait counter is 4 bits wide; the opcode is zero-extended onto the bus.
   if (TIMEOUT < 1 || TIMEOUT > 16) begin : g_bad_timeout
      $error("alu_bus_master: TIMEOUT must be within 1..16");
   end
   if (WORDSIZE < 4) begin : g_bad_wordsize
      $error("alu_bus_master: WORDSIZE must be at least 4");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_LA, S_LB, S_LF, S_LOP, S_COMP, S_RDY, S_RDF, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [WORDSIZE-1:0] a_q, b_q, f_q, y_cap;
   logic [3:0]          op_q;
   logic                use_f_q;
   logic                timeout_hit;

`ifdef ALU_MASTER_TIMEOUT_EN
   localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
   logic [3:0] wait_cnt;

   assign timeout_hit = ((state_q == S_RDY) || (state_q == S_RDF)) &&
                        !i_valid && (wait_cnt == WAIT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (i_start) state_d = S_LA;
         S_LA:   state_d = S_LB;
         S_LB:   state_d = use_f_q ? S_LF : S_LOP;
         S_LF:   state_d = S_LOP;
         S_LOP:  state_d = S_COMP;
         S_COMP: state_d = S_RDY;
         S_RDY: begin
            if (i_valid)          state_d = S_RDF;
            else if (timeout_hit) state_d = S_DONE;
         end
         S_RDF:  if (i_valid || timeout_hit) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_command = COM_NOP;
      o_data    = '0;
      o_valid   = 1'b0;
      case (state_q)
         S_LA: begin
            o_command = COM_LATCHA;
            o_data    = a_q;
            o_valid   = 1'b1;
         end
         S_LB: begin
            o_command = COM_LATCHB;
            o_data    = b_q;
            o_valid   = 1'b1;
         end
         S_LF: begin
            o_command = COM_LATCHF;
            o_data    = f_q;
            o_valid   = 1'b1;
         end
         S_LOP: begin
            o_command = COM_LATCHOP;
            o_data    = {{(WORDSIZE-4){1'b0}}, op_q};
            o_valid   = 1'b1;
         end
         S_COMP:  o_command = COM_COMPUTE;
         S_RDY:   o_command = COM_OUTPUTY;
         S_RDF:   o_command = COM_OUTPUTF;
         default: o_command = COM_NOP;
      endcase
   end

   assign o_busy = (state_q != S_IDLE);
   assign o_done = (state_q == S_DONE);

   // Y is held in y_cap until the sequence ends so that o_y only moves on done.
   // Reaching RDF means Y was read, so o_y is published even if F times out.
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         op_q    <= '0;
         use_f_q <= 1'b0;
         y_cap   <= '0;
         o_y     <= '0;
         o_flags <= '0;
      end else begin
         if (state_q == S_IDLE && i_start) begin
            a_q     <= i_a;
            b_q     <= i_b;
            f_q     <= i_f;
            op_q    <= i_op;
            use_f_q <= i_use_f;
         end
         if (state_q == S_RDY && i_valid) y_cap <= i_data;
         if (state_q == S_RDF && state_d == S_DONE) begin
            o_y <= y_cap;
            if (i_valid) o_flags <= i_data;
         end
      end
   end

`ifdef ALU_MASTER_TIMEOUT_EN
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         wait_cnt <= '0;
         o_error  <= 1'b0;
      end else begin
         if (state_d != state_q)
            wait_cnt <= '0;
         else if (state_q == S_RDY || state_q == S_RDF)
            wait_cnt <= wait_cnt + 4'd1;
         o_error <= timeout_hit && (state_d == S_DONE);
      end
   end
`else
   assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_alu_bus_master.sv
module tb_alu_bus_master;

   localparam int W  = 16;
   localparam int TO = 8;

   localparam logic [3:0] C_NOP = 4'd0, C_LA = 4'd1, C_LB = 4'd2, C_LF = 4'd3,
                          C_LOP = 4'd4, C_COMP = 4'd5, C_OY = 4'd6, C_OF = 4'd7;
   localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_AND = 4'd2, OP_XOR = 4'd3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_start = 1'b0;
   logic [W-1:0] i_a = '0, i_b = '0, i_f = '0;
   logic [3:0]   i_op = '0;
   logic         i_use_f = 1'b0;
   logic         o_busy, o_done, o_error, o_valid;
   logic [W-1:0] o_y, o_flags, o_data;
   logic [3:0]   o_command;
   logic [W-1:0] i_data;
   logic         i_valid;

   int n_chk = 0;
   int n_fail = 0;

   alu_bus_master #(.WORDSIZE(W), .TIMEOUT(TO)) dut (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_start(i_start),
      .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_use_f(i_use_f), .i_f(i_f),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_y(o_y), .o_flags(o_flags), .o_command(o_command),
      .o_data(o_data), .o_valid(o_valid), .i_data(i_data), .i_valid(i_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ALU result: y in [15:0], carry in bit 16, zero in bit 17.
   function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] f);
      logic [W:0] s;
      case (op)
         OP_ADD:  s = {1'b0, a} + {1'b0, b};
         OP_ADC:  s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, f[0]};
         OP_AND:  s = {1'b0, a & b};
         OP_XOR:  s = {1'b0, a ^ b};
         default: s = '0;
      endcase
      return {14'd0, (s[W-1:0] == '0), s[W], s[W-1:0]};
   endfunction

   // ALU responder on the bus
   logic [W-1:0] alu_a = '0, alu_b = '0, alu_f = '0, alu_y = '0, alu_fo = '0;
   logic [3:0]   alu_op = '0;
   int ycnt = 0, fcnt = 0, stall_y = 0, stall_f = 0;

   always @(posedge clk) begin
      logic [31:0] r;
      if (o_valid) begin
         case (o_command)
            C_LA:  alu_a  <= o_data;
            C_LB:  alu_b  <= o_data;
            C_LF:  alu_f  <= o_data;
            C_LOP: alu_op <= o_data[3:0];
            default: ;
         endcase
      end
      if (o_command == C_COMP) begin
         r = alu_calc(alu_op, alu_a, alu_b, alu_f);
         alu_y  <= r[15:0];
         alu_fo <= {14'd0, r[17:16]};
      end
      ycnt <= (o_command == C_OY) ? ycnt + 1 : 0;
      fcnt <= (o_command == C_OF) ? fcnt + 1 : 0;
   end

   always_comb begin
      i_valid = 1'b0;
      i_data  = '0;
      if (o_command == C_OY && ycnt >= stall_y) begin
         i_valid = 1'b1;
         i_data  = alu_y;
      end else if (o_command == C_OF && fcnt >= stall_f) begin
         i_valid = 1'b1;
         i_data  = alu_fo;
      end
   end

   // Expected per-cycle bus/handshake behaviour
   typedef struct {
      logic [3:0]   cmd;
      logic [W-1:0] data;
      logic         vld, busy, done, err, new_y, new_f;
      logic [W-1:0] y, f;
   } rec_t;

   rec_t exp_q[$];
   logic [W-1:0] cur_y = '0, cur_f = '0;

   function automatic rec_t mk(input logic [3:0] cmd, input logic [W-1:0] data,
                               input logic vld, input logic busy);
      rec_t r;
      r.cmd = cmd; r.data = data; r.vld = vld; r.busy = busy;
      r.done = 1'b0; r.err = 1'b0; r.new_y = 1'b0; r.new_f = 1'b0;
      r.y = '0; r.f = '0;
      return r;
   endfunction

   always @(negedge clk) begin
      rec_t r;
      if (!rst_n) begin
         cur_y = '0;
         cur_f = '0;
         chk("rst_cmd", 32'(o_command), 32'd0);
         chk("rst_data", 32'(o_data), 32'd0);
         chk("rst_ctl", {28'd0, o_valid, o_busy, o_done, o_error}, 32'd0);
         chk("rst_y", 32'(o_y), 32'd0);
         chk("rst_flags", 32'(o_flags), 32'd0);
      end else begin
         if (exp_q.size() > 0) r = exp_q.pop_front();
         else                  r = mk(C_NOP, '0, 1'b0, 1'b0);
         chk("cmd", 32'(o_command), 32'(r.cmd));
         chk("data", 32'(o_data), 32'(r.data));
         chk("valid", 32'(o_valid), 32'(r.vld));
         chk("busy", 32'(o_busy), 32'(r.busy));
         chk("done", 32'(o_done), 32'(r.done));
         chk("error", 32'(o_error), 32'(r.err));
         if (r.done) begin
            if (r.new_y) cur_y = r.y;
            if (r.new_f) cur_f = r.f;
         end
         chk("y_hold", 32'(o_y), 32'(cur_y));
         chk("flags_hold", 32'(o_flags), 32'(cur_f));
      end
   end

   bit to_en;

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         input logic use_f, input logic [W-1:0] f,
                         input int sy, input int sf, input int poke, input int rst_at,
                         input int exp_lat, input logic [W-1:0] exp_y,
                         input logic [W-1:0] exp_fl, input logic exp_err);
      logic [31:0] m;
      rec_t r;
      int done_c;
      m = alu_calc(op, a, b, f);
      stall_y = sy;
      stall_f = sf;
      @(posedge clk);
      #1;
      i_a = a; i_b = b; i_op = op; i_use_f = use_f; i_f = f; i_start = 1'b1;
      exp_q.push_back(mk(C_NOP, '0, 1'b0, 1'b0));
      exp_q.push_back(mk(C_LA, a, 1'b1, 1'b1));
      exp_q.push_back(mk(C_LB, b, 1'b1, 1'b1));
      if (use_f) exp_q.push_back(mk(C_LF, f, 1'b1, 1'b1));
      exp_q.push_back(mk(C_LOP, {12'd0, op}, 1'b1, 1'b1));
      exp_q.push_back(mk(C_COMP, '0, 1'b0, 1'b1));
      r = mk(C_NOP, '0, 1'b0, 1'b1);
      r.done = 1'b1;
      r.y = m[15:0];
      r.f = {14'd0, m[17:16]};
      if (to_en && sy >= TO) begin
         repeat (TO) exp_q.push_back(mk(C_OY, '0, 1'b0, 1'b1));
         r.err = 1'b1;
      end else begin
         repeat (sy + 1) exp_q.push_back(mk(C_OY, '0, 1'b0, 1'b1));
         r.new_y = 1'b1;
         if (to_en && sf >= TO) begin
            repeat (TO) exp_q.push_back(mk(C_OF, '0, 1'b0, 1'b1));
            r.err = 1'b1;
         end else begin
            repeat (sf + 1) exp_q.push_back(mk(C_OF, '0, 1'b0, 1'b1));
            r.new_f = 1'b1;
         end
      end
      exp_q.push_back(r);
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_a = 16'hDEAD; i_b = 16'hBEEF; i_op = 4'hF; i_f = 16'hFFFF; i_use_f = ~use_f;
      done_c = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         #1;
         if (c == rst_at) begin
            rst_n = 1'b0;
            i_start = 1'b0;
            exp_q.delete();
            repeat (2) @(negedge clk);
            #1;
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            return;
         end
         if (c == poke) begin
            i_start = 1'b1;
            i_a = 16'h5555; i_b = 16'h5555; i_op = OP_XOR;
         end else begin
            i_start = 1'b0;
         end
         if (o_done) begin
            done_c = c;
            break;
         end
      end
      chk("done_seen", 32'(done_c != 0), 32'd1);
      chk("latency", 32'(done_c), 32'(exp_lat));
      chk("y_lit", 32'(o_y), 32'(exp_y));
      chk("flags_lit", 32'(o_flags), 32'(exp_fl));
      chk("err_lit", 32'(o_error), 32'(exp_err));
      @(negedge clk);
      #1;
      i_start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
`ifdef ALU_MASTER_TIMEOUT_EN
      to_en = 1'b1;
`else
      to_en = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      //      a        b        op      uf    f       sy sf poke rst lat y        flags    err
      run_op(16'h0003, 16'h0004, OP_ADD, 1'b0, 16'h0, 0, 0, 0, 0, 7, 16'h0007, 16'h0000, 1'b0);
      run_op(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 16'h0, 0, 0, 0, 0, 7, 16'h0000, 16'h0003, 1'b0);
      run_op(16'h0001, 16'h0001, OP_ADC, 1'b1, 16'h1, 0, 0, 0, 0, 8, 16'h0003, 16'h0000, 1'b0);
      run_op(16'h1000, 16'h0234, OP_ADD, 1'b0, 16'h0, 0, 0, 2, 0, 7, 16'h1234, 16'h0000, 1'b0);
      run_op(16'hF0F0, 16'h0FF0, OP_XOR, 1'b0, 16'h0, 0, 0, 7, 0, 7, 16'hFF00, 16'h0000, 1'b0);
      run_op(16'h00FF, 16'h0F0F, OP_AND, 1'b1, 16'h0, 2, 1, 0, 0, 11, 16'h000F, 16'h0000, 1'b0);
      run_op(16'h1111, 16'h2222, OP_ADD, 1'b0, 16'h0, 0, 0, 0, 4, 0, 16'h0000, 16'h0000, 1'b0);
      chk("post_rst_y", 32'(o_y), 32'd0);
      run_op(16'h0100, 16'h0001, OP_ADD, 1'b0, 16'h0, 0, 0, 0, 0, 7, 16'h0101, 16'h0000, 1'b0);
`ifdef ALU_MASTER_TIMEOUT_EN
      run_op(16'h0005, 16'h0006, OP_ADD, 1'b0, 16'h0, 100, 0, 0, 0, 13, 16'h0101, 16'h0000, 1'b1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
